// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serializes the WRITE DATA byte into a UART frame
// (start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits)
// at a bit period of baud_div+1 pclk cycles. Feeds busy/done/overrun
// indications back to the STATUS register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | line low for one bit period
// DATA   | line = shift[0], shift right at each bit end
// PARITY | line = parity of latched data (XOR PARITY_ODD), one bit period
// STOP   | line high for STOP_BITS bit periods; tx_done on the last cycle

module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        tx_start,
    input  logic [15:0] tx_data,
    input  logic [15:0] baud_div,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);
    localparam logic       ONE_STOP  = (STOP_BITS == 1);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);
    localparam logic       ODD       = (PARITY_ODD != 0);

    state_t                 state;
    logic [DATA_BITS-1:0]   shift;
    logic                   par;
    logic [15:0]            div_q;
    logic [15:0]            baud_cnt;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;

    logic bit_end;
    logic last_stop;
    logic div_zero;
    logic unused_data_hi;

    assign bit_end   = (baud_cnt == 16'd0);
    assign last_stop = (stop_cnt == LAST_STOP);
    assign div_zero  = (div_q == 16'd0);

    // bits above DATA_BITS are deliberately ignored
    assign unused_data_hi = &{1'b0, tx_data[15:DATA_BITS]};

    // Frame sequencer: all outputs registered; tx_done is set one edge
    // early so that it coincides with the final stop cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state      <= IDLE;
            shift      <= '0;
            par        <= 1'b0;
            div_q      <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_overrun <= tx_start && tx_busy;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift    <= tx_data[DATA_BITS-1:0];
                        par      <= (^tx_data[DATA_BITS-1:0]) ^ ODD;
                        div_q    <= baud_div;
                        baud_cnt <= baud_div;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        uart_tx  <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= div_q;
                        uart_tx  <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div_q;
                        shift    <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                uart_tx <= par;
                                state   <= PARITY;
                            end else begin
                                uart_tx  <= 1'b1;
                                stop_cnt <= 1'b0;
                                tx_done  <= div_zero && ONE_STOP;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= div_q;
                        uart_tx  <= 1'b1;
                        stop_cnt <= 1'b0;
                        tx_done  <= div_zero && ONE_STOP;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            uart_tx <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                            baud_cnt <= div_q;
                            tx_done  <= div_zero;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                        tx_done  <= (baud_cnt == 16'd1) && last_stop;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four configurations driven with the same
// stimulus, each compared cycle by cycle against a frame-level model.

module tb_uart_tx_engine;

    localparam int NI = 4;

    logic          pclk;
    logic          preset_n;
    logic          tx_start;
    logic [15:0]   tx_data;
    logic [15:0]   baud_div;
    logic [NI-1:0] tx_l;
    logic [NI-1:0] busy_l;
    logic [NI-1:0] done_l;
    logic [NI-1:0] ovr_l;

    int n_chk = 0;
    int n_err = 0;

    // frame-level reference model state, one slot per instance
    bit          m_act [NI];
    bit          m_ovr [NI];
    int unsigned m_pos [NI];
    int unsigned m_len [NI];
    int unsigned m_div [NI];
    bit          m_lv  [NI][16];

    int busy_cnt [NI];
    int done_cnt [NI];
    int ovr_cnt  [NI];

    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .pclk(pclk), .preset_n(preset_n), .tx_start(tx_start), .tx_data(tx_data),
        .baud_div(baud_div), .uart_tx(tx_l[0]), .tx_busy(busy_l[0]),
        .tx_done(done_l[0]), .tx_overrun(ovr_l[0]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .pclk(pclk), .preset_n(preset_n), .tx_start(tx_start), .tx_data(tx_data),
        .baud_div(baud_div), .uart_tx(tx_l[1]), .tx_busy(busy_l[1]),
        .tx_done(done_l[1]), .tx_overrun(ovr_l[1]));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .pclk(pclk), .preset_n(preset_n), .tx_start(tx_start), .tx_data(tx_data),
        .baud_div(baud_div), .uart_tx(tx_l[2]), .tx_busy(busy_l[2]),
        .tx_done(done_l[2]), .tx_overrun(ovr_l[2]));
    uart_tx_engine #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u3 (
        .pclk(pclk), .preset_n(preset_n), .tx_start(tx_start), .tx_data(tx_data),
        .baud_div(baud_div), .uart_tx(tx_l[3]), .tx_busy(busy_l[3]),
        .tx_done(done_l[3]), .tx_overrun(ovr_l[3]));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic int cfg_db(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic bit cfg_pe(input int i);
        return (i != 0);
    endfunction
    function automatic bit cfg_po(input int i);
        return (i == 3);
    endfunction
    function automatic int cfg_sb(input int i);
        return (i >= 2) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance the model across one rising edge using the inputs seen there
    task automatic model_edge(input int i);
        int unsigned n;
        bit p;
        m_ovr[i] = 1'b0;
        if (!preset_n) begin
            m_act[i] = 1'b0;
            m_pos[i] = 0;
            return;
        end
        if (m_act[i]) begin
            if (tx_start) m_ovr[i] = 1'b1;
            m_pos[i]++;
            if (m_pos[i] == m_len[i]) m_act[i] = 1'b0;
        end else if (tx_start) begin
            n = 0;
            p = cfg_po(i);
            m_lv[i][n] = 1'b0; n++;
            for (int b = 0; b < cfg_db(i); b++) begin
                m_lv[i][n] = tx_data[b];
                p = p ^ tx_data[b];
                n++;
            end
            if (cfg_pe(i)) begin
                m_lv[i][n] = p; n++;
            end
            for (int s = 0; s < cfg_sb(i); s++) begin
                m_lv[i][n] = 1'b1; n++;
            end
            m_div[i] = baud_div;
            m_len[i] = n * (m_div[i] + 1);
            m_pos[i] = 0;
            m_act[i] = 1'b1;
        end
    endtask

    // one clock: model update at the rising edge, compare at the falling edge
    task automatic tick();
        bit e_tx;
        @(posedge pclk);
        for (int i = 0; i < NI; i++) model_edge(i);
        @(negedge pclk);
        for (int i = 0; i < NI; i++) begin
            e_tx = m_act[i] ? m_lv[i][m_pos[i] / (m_div[i] + 1)] : 1'b1;
            check($sformatf("uart_tx[%0d]", i), tx_l[i], e_tx);
            check($sformatf("tx_busy[%0d]", i), busy_l[i], m_act[i]);
            check($sformatf("tx_done[%0d]", i), done_l[i],
                  m_act[i] && (m_pos[i] == m_len[i] - 1));
            check($sformatf("tx_overrun[%0d]", i), ovr_l[i], m_ovr[i]);
            busy_cnt[i] += busy_l[i];
            done_cnt[i] += done_l[i];
            ovr_cnt[i]  += ovr_l[i];
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NI; i++) begin
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            ovr_cnt[i]  = 0;
        end
    endtask

    task automatic pulse_start(input logic [15:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_done0(input int budget, input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!done_l[0] && k < budget);
        check(tag, done_l[0], 1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 0; m_ovr[i] = 0; m_pos[i] = 0; m_len[i] = 1; m_div[i] = 0;
        end
        clear_counts();
        preset_n = 1'b0;
        tx_start = 1'b0;
        tx_data  = 16'h0000;
        baud_div = 16'd3;
        idle(2);
        check("reset_uart_tx", tx_l, 4'hF);
        check("reset_busy", busy_l, 4'h0);
        check("reset_done_ovr", {done_l, ovr_l}, 8'h00);
        preset_n = 1'b1;
        idle(2);

        // basic 0xA5 frame at 4 cycles per bit
        clear_counts();
        pulse_start(16'h00A5);
        wait_done0(100, "basic_done_timeout");
        check("basic_busy_len", busy_cnt[0], 40);
        check("basic_done_cnt", done_cnt[0], 1);
        idle(60);

        // parity variants at one cycle per bit
        clear_counts();
        baud_div = 16'd0;
        pulse_start(16'h0007);
        idle(20);
        check("par_len_8n1", busy_cnt[0], 10);
        check("par_len_8e1", busy_cnt[1], 11);
        check("par_len_8e2", busy_cnt[2], 12);
        check("par_len_5o2", busy_cnt[3], 9);

        // overrun five cycles into a frame
        clear_counts();
        baud_div = 16'd1;
        pulse_start(16'h0055);
        idle(4);
        pulse_start(16'h00FF);
        idle(40);
        check("ovr_cnt", ovr_cnt[0], 1);
        check("ovr_busy_len", busy_cnt[0], 20);
        check("ovr_done_cnt", done_cnt[0], 1);

        // start on the tx_done cycle overruns; the cycle after starts a frame
        clear_counts();
        baud_div = 16'd3;
        pulse_start(16'h00C3);
        wait_done0(100, "b2b_first_timeout");
        tx_data  = 16'h003C;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("b2b_done_ovr", ovr_l[0], 1);
        check("b2b_idle_gap", {tx_l[0], busy_l[0]}, 2'b10);
        pulse_start(16'h003C);
        check("b2b_start_low", {tx_l[0], busy_l[0]}, 2'b01);
        wait_done0(100, "b2b_second_timeout");
        check("b2b_done_cnt", done_cnt[0], 2);
        idle(60);

        // async reset during data bit 3, then a clean frame
        pulse_start(16'h00A5);
        idle(17);
        #2 preset_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_l, 4'hF);
        check("rst_mid_busy", busy_l, 4'h0);
        tick();
        preset_n = 1'b1;
        tick();
        clear_counts();
        pulse_start(16'h0081);
        wait_done0(100, "rst_after_timeout");
        check("rst_after_len", busy_cnt[0], 40);
        idle(60);

        // divisor changed mid-frame only affects the next frame
        clear_counts();
        baud_div = 16'd3;
        pulse_start(16'h00C3);
        idle(10);
        baud_div = 16'd7;
        wait_done0(100, "div_first_timeout");
        check("div_old_len", busy_cnt[0], 40);
        idle(20);
        clear_counts();
        pulse_start(16'h00C3);
        wait_done0(200, "div_second_timeout");
        check("div_new_len", busy_cnt[0], 80);
        idle(100);

        // randomized traffic, occasional resets
        for (int c = 0; c < 4000; c++) begin
            tx_start = ($urandom_range(0, 9) == 0);
            tx_data  = 16'($urandom);
            if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) preset_n = 1'b0;
            tick();
            preset_n = 1'b1;
        end
        tx_start = 1'b0;
        idle(100);
        check("final_idle_busy", busy_l, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
